// File: rtl/ledkey_pkg.sv
// Shared constants, FSM state type and command decoding for the LED&KEY responder.
package ledkey_pkg;

    // Command class, taken from bits 7:6 of the first byte of a frame.
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Bit positions inside a data command.
    localparam int unsigned DATA_READ_BIT  = 1;
    localparam int unsigned DATA_FIXED_BIT = 2;

    // Bit positions inside a display-control command.
    localparam int unsigned DISP_ON_BIT = 3;

    localparam int unsigned NUM_DISP_REGS = 16;
    localparam int unsigned KEY_BYTES     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } lk_state_e;

    // Frame state entered once the command byte has been received.
    function automatic lk_state_e cmd_target(input logic [7:0] cmd);
        lk_state_e nxt;
        nxt = ST_IGNORE;
        case (cmd[7:6])
            CMD_ADDR: nxt = ST_WDATA;
            CMD_DATA: nxt = cmd[DATA_READ_BIT] ? ST_RDATA : ST_IGNORE;
            default:  nxt = ST_IGNORE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ledkey_if.sv
// Three-wire LED&KEY bus: controller drives clock, strobe and data-in;
// the responder returns data with an output enable.
interface ledkey_if;

    logic lk_clk;
    logic lk_stb;
    logic lk_dio_i;
    logic lk_dio_o;
    logic lk_dio_oe;

    modport master (
        output lk_clk,
        output lk_stb,
        output lk_dio_i,
        input  lk_dio_o,
        input  lk_dio_oe
    );

    modport slave (
        input  lk_clk,
        input  lk_stb,
        input  lk_dio_i,
        output lk_dio_o,
        output lk_dio_oe
    );

endinterface

// File: rtl/ledkey_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus pin, with registered
// rise/fall pulses. The level output is aligned with the pulses, so a
// pin edge shows up on all three outputs SYNC_STAGES+1 cycles later.
module ledkey_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain, delayed copy and edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            prev_q <= IDLE_LEVEL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;

endmodule

// File: rtl/ledkey_responder.sv
// TM1638-style responder: decodes strobe-framed command/data bytes into a
// 16-byte display register file and display-control state, and shifts a
// 32-bit key snapshot back to the controller on read commands.
module ledkey_responder
    import ledkey_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ledkey_if.slave                bus,
    input  logic [8*KEY_BYTES-1:0] keys,
    output logic [127:0]           disp_regs,
    output logic                   disp_on,
    output logic [2:0]             brightness,
    output logic                   frame_done,
    output logic                   cmd_err
);

    logic clk_lvl, clk_rise, clk_fall;
    logic stb_lvl, stb_rise, stb_fall;
    logic dio_lvl, dio_rise, dio_fall;

    ledkey_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.lk_clk),
        .level (clk_lvl),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    ledkey_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_stb (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.lk_stb),
        .level (stb_lvl),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    ledkey_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_dio (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.lk_dio_i),
        .level (dio_lvl),
        .rise  (dio_rise),
        .fall  (dio_fall)
    );

    // Synchronizer outputs this block has no use for.
    logic unused_sync;
    assign unused_sync = ^{clk_lvl, dio_rise, dio_fall};

    lk_state_e state_q, state_d;

    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   byte_seen_q;
    logic [3:0]             addr_q;
    logic                   fixed_q;
    logic [8*KEY_BYTES-1:0] key_sh_q;
    logic                   dio_o_q;
    logic                   dio_oe_q;
    logic [7:0]             regs_q [NUM_DISP_REGS];

    logic       in_frame;
    logic       bit_ev;
    logic       byte_done;
    logic       rd_ev;
    logic [7:0] byte_in;

    // A strobe rise in the same cycle as a clock edge closes the frame and
    // suppresses that edge.
    assign in_frame  = (state_q != ST_IDLE);
    assign bit_ev    = in_frame && clk_rise && !stb_rise && !stb_lvl;
    assign byte_done = bit_ev && (bit_cnt_q == 3'd7);
    assign rd_ev     = (state_q == ST_RDATA) && clk_fall && !stb_rise;
    assign byte_in   = {dio_lvl, shift_q[7:1]};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: strobe rise returns to IDLE from anywhere in a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (stb_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (stb_rise)       state_d = ST_IDLE;
                else if (byte_done) state_d = cmd_target(byte_in);
            end
            default: begin
                if (stb_rise) state_d = ST_IDLE;
            end
        endcase
    end

    // Bit/byte assembly, command execution, register writes and key readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_seen_q <= 1'b0;
            addr_q      <= '0;
            fixed_q     <= 1'b0;
            key_sh_q    <= '0;
            dio_o_q     <= 1'b1;
            dio_oe_q    <= 1'b0;
            disp_on     <= 1'b0;
            brightness  <= '0;
            frame_done  <= 1'b0;
            cmd_err     <= 1'b0;
            for (int unsigned i = 0; i < NUM_DISP_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;

            if (stb_fall) begin
                bit_cnt_q   <= '0;
                byte_seen_q <= 1'b0;
            end

            if (stb_rise) begin
                bit_cnt_q  <= '0;
                frame_done <= in_frame && byte_seen_q;
                dio_o_q    <= 1'b1;
                dio_oe_q   <= 1'b0;
            end

            if (bit_ev) begin
                shift_q   <= byte_in;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (byte_done) begin
                byte_seen_q <= 1'b1;
                if (state_q == ST_CMD) begin
                    case (byte_in[7:6])
                        CMD_DATA: begin
                            fixed_q <= byte_in[DATA_FIXED_BIT];
                            if (byte_in[DATA_READ_BIT]) key_sh_q <= keys;
                        end
                        CMD_ADDR: addr_q <= byte_in[3:0];
                        CMD_DISP: begin
                            disp_on    <= byte_in[DISP_ON_BIT];
                            brightness <= byte_in[2:0];
                        end
                        default: cmd_err <= 1'b1;
                    endcase
                end else if (state_q == ST_WDATA) begin
                    regs_q[addr_q] <= byte_in;
                    if (!fixed_q) addr_q <= addr_q + 4'd1;
                end
            end

            if (rd_ev) begin
                dio_o_q  <= key_sh_q[0];
                dio_oe_q <= 1'b1;
                key_sh_q <= {1'b0, key_sh_q[8*KEY_BYTES-1:1]};
            end
        end
    end

    // Flatten the register file onto the display bus.
    always_comb begin
        disp_regs = '0;
        for (int unsigned i = 0; i < NUM_DISP_REGS; i++) begin
            disp_regs[8*i +: 8] = regs_q[i];
        end
    end

    assign bus.lk_dio_o  = dio_o_q;
    assign bus.lk_dio_oe = dio_oe_q;

endmodule

// File: tb/tb_ledkey_responder.sv
// Directed and randomized frames against a byte-level model of the device.
module tb_ledkey_responder;

    localparam int unsigned HALF = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  keys;
    logic [127:0] disp_regs;
    logic         disp_on;
    logic [2:0]   brightness;
    logic         frame_done;
    logic         cmd_err;

    ledkey_if bus ();

    ledkey_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .keys       (keys),
        .disp_regs  (disp_regs),
        .disp_on    (disp_on),
        .brightness (brightness),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int ce_cnt = 0;
    int exp_fd = 0;
    int exp_ce = 0;

    logic [7:0] m_regs [16];
    logic       m_fixed;
    logic       m_on;
    logic [2:0] m_bri;
    logic [7:0] fq [$];

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (cmd_err === 1'b1) ce_cnt++;
    end

    initial begin
        #50000000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_bits(input logic [7:0] b, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            bus.lk_clk   = 1'b0;
            bus.lk_dio_i = b[i];
            tick(HALF);
            bus.lk_clk = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic stb_low();
        bus.lk_stb = 1'b0;
        tick(HALF);
    endtask

    task automatic stb_high();
        tick(HALF);
        bus.lk_stb = 1'b1;
        tick(HALF + 4);
    endtask

    function automatic logic [127:0] m_pack();
        logic [127:0] r;
        for (int unsigned i = 0; i < 16; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    // Device behaviour for one frame of complete bytes held in fq.
    task automatic model_frame();
        int unsigned a;
        logic [7:0] c;
        if (fq.size() == 0) return;
        exp_fd++;
        c = fq[0];
        case (c[7:6])
            2'b01: m_fixed = c[2];
            2'b11: begin
                a = c[3:0];
                for (int unsigned k = 1; k < fq.size(); k++) begin
                    m_regs[a] = fq[k];
                    if (!m_fixed) a = (a + 1) % 16;
                end
            end
            2'b10: begin
                m_on  = c[3];
                m_bri = c[2:0];
            end
            default: exp_ce++;
        endcase
    endtask

    task automatic write_frame();
        stb_low();
        foreach (fq[k]) bus_bits(fq[k], 8);
        stb_high();
        model_frame();
    endtask

    task automatic check_state(input string tag);
        check({tag, " regs"}, disp_regs, m_pack());
        check({tag, " disp_on"}, 128'(disp_on), 128'(m_on));
        check({tag, " brightness"}, 128'(brightness), 128'(m_bri));
        check({tag, " frame_done count"}, 128'(fd_cnt), 128'(exp_fd));
        check({tag, " cmd_err count"}, 128'(ce_cnt), 128'(exp_ce));
    endtask

    task automatic read_frame(input logic [7:0] cmd, input logic [31:0] kv);
        logic [7:0] got;
        logic       oe_all;
        keys = kv;
        stb_low();
        bus_bits(cmd, 8);
        tick(2 * HALF);
        for (int unsigned k = 0; k < 4; k++) begin
            got    = '0;
            oe_all = 1'b1;
            for (int unsigned i = 0; i < 8; i++) begin
                bus.lk_clk = 1'b0;
                tick(HALF);
                got[i] = bus.lk_dio_o;
                oe_all = oe_all & bus.lk_dio_oe;
                bus.lk_clk = 1'b1;
                tick(HALF);
            end
            check($sformatf("read byte%0d", k), 128'(got), 128'((kv >> (8 * k)) & 32'hFF));
            check($sformatf("read oe byte%0d", k), 128'(oe_all), 128'(1'b1));
        end
        stb_high();
        check("read oe after stb", 128'(bus.lk_dio_oe), 128'(1'b0));
        check("read dio after stb", 128'(bus.lk_dio_o), 128'(1'b1));
        m_fixed = cmd[2];
        exp_fd++;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  c;

        bus.lk_clk   = 1'b1;
        bus.lk_stb   = 1'b1;
        bus.lk_dio_i = 1'b1;
        keys         = '0;
        for (int unsigned i = 0; i < 16; i++) m_regs[i] = '0;
        m_fixed = 1'b0;
        m_on    = 1'b0;
        m_bri   = '0;

        // Reset state.
        tick(5);
        rst_n = 1'b1;
        tick(5);
        check("reset disp_regs", disp_regs, '0);
        check("reset oe", 128'(bus.lk_dio_oe), 128'(1'b0));
        check("reset dio_o", 128'(bus.lk_dio_o), 128'(1'b1));
        check("reset brightness", 128'(brightness), 128'(3'd0));
        check("reset disp_on", 128'(disp_on), 128'(1'b0));
        check("reset frame_done", 128'(frame_done), 128'(1'b0));
        check("reset cmd_err", 128'(cmd_err), 128'(1'b0));

        // Auto-increment fill of all 16 registers.
        fq = '{8'h40};
        write_frame();
        fq = '{8'hC0};
        for (int unsigned i = 0; i < 16; i++) fq.push_back(8'(i));
        write_frame();
        check_state("fill16");
        check("fill16 reg9", 128'(disp_regs[79:72]), 128'(8'h09));

        // Fixed address, then auto-increment wrap from 15 to 0.
        fq = '{8'h44};
        write_frame();
        fq = '{8'hC5, 8'hAA, 8'h55};
        write_frame();
        check_state("fixed");
        check("fixed reg5", 128'(disp_regs[47:40]), 128'(8'h55));
        check("fixed reg6 kept", 128'(disp_regs[55:48]), 128'(8'h06));
        fq = '{8'h40};
        write_frame();
        fq = '{8'hCF, 8'h11, 8'h22};
        write_frame();
        check_state("wrap");
        check("wrap reg15", 128'(disp_regs[127:120]), 128'(8'h11));
        check("wrap reg0", 128'(disp_regs[7:0]), 128'(8'h22));

        // Key readout.
        read_frame(8'h42, 32'h04030201);
        check_state("read");

        // Display control and undefined command.
        fq = '{8'h8C};
        write_frame();
        check_state("dispctl");
        check("dispctl on", 128'(disp_on), 128'(1'b1));
        check("dispctl bri", 128'(brightness), 128'(3'd4));
        fq = '{8'h00};
        write_frame();
        check_state("undef");

        // Strobe rise mid-byte discards the partial byte.
        stb_low();
        bus_bits(8'hC3, 8);
        bus_bits(8'hFF, 5);
        stb_high();
        exp_fd++;
        check_state("partial");
        fq = '{8'hC3, 8'h5A};
        write_frame();
        check_state("after partial");

        // Frames with no complete byte produce no frame_done.
        stb_low();
        stb_high();
        check_state("empty frame");
        stb_low();
        bus_bits(8'h8F, 3);
        stb_high();
        check_state("short frame");

        // Randomized frames.
        for (int unsigned it = 0; it < 12; it++) begin
            r = $urandom;
            case (r[31:30])
                2'd0: begin
                    fq = '{8'h40 | (r[7:0] & 8'h0D)};
                    write_frame();
                    fq = '{8'hC0 | {4'h0, r[11:8]}};
                    for (int unsigned k = 0; k < $urandom_range(1, 6); k++) fq.push_back(8'($urandom));
                    write_frame();
                end
                2'd1: begin
                    read_frame(8'h42 | (r[7:0] & 8'h0D), $urandom);
                end
                2'd2: begin
                    fq = '{8'h80 | {4'h0, r[3:0]}, r[15:8]};
                    write_frame();
                end
                default: begin
                    c  = r[7:0] & 8'h3F;
                    fq = '{c, r[15:8]};
                    write_frame();
                end
            endcase
            check_state($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
